// File: rtl/sw_debounce.sv
// sw_debounce
//   Conditions a bank of raw board switches into clean levels for the core.
//   Each bit is brought into the clock domain through a two-flop
//   synchronizer. On every sample tick the synchronized value is compared
//   against the accepted level. A new level is taken only after STABLE_CNT
//   consecutive ticks that all disagree with the current level.
//
// Parameters
//   WIDTH       number of switch bits conditioned
//   TICK_DIV    clock cycles per sample tick (>= 1)
//   STABLE_CNT  consecutive disagreeing ticks needed to accept a level (>= 1)
//
// Ports
//   i_clk          clock, rising edge active
//   i_reset        asynchronous active-high reset
//   i_sw_raw       raw asynchronous switch inputs
//   o_sw           debounced level (drives the core's i_io_sw)
//   o_rise         one-cycle pulse per bit on an accepted 0->1 change
//   o_fall         one-cycle pulse per bit on an accepted 1->0 change
//   o_tick         sample strobe, high one cycle in every TICK_DIV
//   o_evt_pending  sticky flag, set by any rise/fall pulse
//   i_evt_clr      clears o_evt_pending (a simultaneous set wins)
module sw_debounce #(
    parameter int WIDTH      = 32,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_sw_raw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_tick,
    output logic             o_evt_pending,
    input  logic             i_evt_clr
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [WIDTH-1:0]         r_sync1;
    logic [WIDTH-1:0]         r_sync2;
    logic [PW-1:0]            r_pre;
    logic [WIDTH-1:0][CW-1:0] r_cnt;
    logic [WIDTH-1:0]         r_sw;
    logic [WIDTH-1:0]         r_rise;
    logic [WIDTH-1:0]         r_fall;
    logic                     r_evt;

    logic                     w_tick;
    logic [WIDTH-1:0][CW-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]         w_sw_nxt;
    logic [WIDTH-1:0]         w_rise_nxt;
    logic [WIDTH-1:0]         w_fall_nxt;

    // The compare alone would be true during reset when TICK_DIV = 1, so the
    // strobe is additionally held low while reset is asserted.
    assign w_tick = (r_pre == PRE_LAST) && !i_reset;

    // Two-flop synchronizer for the raw switch inputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Prescaler counting 0..TICK_DIV-1 and wrapping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pre <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // Per-bit qualification: next counter, level and edge pulses.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_sw_nxt   = r_sw;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_sw[i]) begin
                    // Any agreeing tick restarts qualification.
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    // Pulses are registered together with the level so they
                    // appear in exactly the first cycle of the new value.
                    w_cnt_nxt[i]  = '0;
                    w_sw_nxt[i]   = r_sync2[i];
                    w_rise_nxt[i] = r_sync2[i];
                    w_fall_nxt[i] = !r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Registered counters, accepted level and edge pulses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_sw   <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_sw   <= w_sw_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    // Sticky event flag; a visible pulse takes priority over a clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_evt <= 1'b0;
        end else if ((|r_rise) || (|r_fall)) begin
            r_evt <= 1'b1;
        end else if (i_evt_clr) begin
            r_evt <= 1'b0;
        end else begin
            r_evt <= r_evt;
        end
    end

    assign o_sw          = r_sw;
    assign o_rise        = r_rise;
    assign o_fall        = r_fall;
    assign o_tick        = w_tick;
    assign o_evt_pending = r_evt;

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

    localparam int W  = 32;
    localparam int TD = 4;
    localparam int SC = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [W-1:0] raw;
    logic [W-1:0] o_sw, o_rise, o_fall;
    logic         o_tick, o_evt;

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_sw_raw     (raw),
        .o_sw         (o_sw),
        .o_rise       (o_rise),
        .o_fall       (o_fall),
        .o_tick       (o_tick),
        .o_evt_pending(o_evt),
        .i_evt_clr    (clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] sw;
        logic         tick;
        logic         evt;
    } exp_t;

    exp_t           exp_q[$];
    logic [2*W-1:0] pulse_q[$];

    // Reference model state: raw pipeline, window of tick samples, level.
    logic [W-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
    logic         m_evt;
    int           m_n;
    logic [W-1:0] m_hist[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model: a level flips for a bit when the last SC tick samples all differ
    // from it; reset empties the sample window.
    always @(posedge clk) begin : model
        exp_t         e;
        logic         tick_now;
        logic [W-1:0] mask;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
            m_evt = 1'b0; m_n = 0;
            m_hist.delete();
        end else begin
            tick_now = (m_n % TD) == (TD - 1);
            m_evt    = ((m_rise | m_fall) != '0) ? 1'b1 : (clr ? 1'b0 : m_evt);
            m_rise   = '0;
            m_fall   = '0;
            if (tick_now) begin
                m_hist.push_back(m_s2);
                if (m_hist.size() > SC) void'(m_hist.pop_front());
                if (m_hist.size() == SC) begin
                    mask = '1;
                    foreach (m_hist[k]) mask &= (m_hist[k] ^ m_lvl);
                    m_rise = mask & ~m_lvl;
                    m_fall = mask & m_lvl;
                    m_lvl  = m_lvl ^ mask;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_n++;
        end
        e.sw   = m_lvl;
        e.tick = !rst && ((m_n % TD) == (TD - 1));
        e.evt  = m_evt;
        exp_q.push_back(e);
        if ((m_rise | m_fall) != '0) pulse_q.push_back({m_rise, m_fall});
    end

    // Monitor: per-cycle level/strobe/flag check, plus pulse transactions.
    always @(posedge clk) begin : monitor
        exp_t           e;
        logic [2*W-1:0] p;
        #1;
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("o_sw", o_sw, e.sw);
            chk("o_tick", W'(o_tick), W'(e.tick));
            chk("o_evt_pending", W'(o_evt), W'(e.evt));
        end
        if ((o_rise | o_fall) != '0) begin
            if (pulse_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL spurious_pulse: rise %h fall %h at %0t", o_rise, o_fall, $time);
            end else begin
                p = pulse_q.pop_front();
                chk("o_rise", o_rise, p[2*W-1:W]);
                chk("o_fall", o_fall, p[W-1:0]);
            end
        end
    end

    task automatic wait_sw(input int b, input logic val, output int lat);
        lat = 0;
        while (o_sw[b] !== val && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_pulse(input bit rise, output logic [W-1:0] v);
        int n;
        n = 0;
        v = '0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            v = rise ? o_rise : o_fall;
            if (v != '0) break;
        end
        if (v == '0) begin
            n_tests++; n_fail++;
            $display("FAIL pulse_timeout: rise=%0d got none within 40 cycles", rise);
        end
    endtask

    initial begin
        int           lat, ticks, hold;
        logic [W-1:0] v;
        rst = 1'b1; raw = '0; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sw", o_sw, '0);
        chk("reset_rise", o_rise, '0);
        chk("reset_fall", o_fall, '0);
        chk("reset_tick", W'(o_tick), '0);
        chk("reset_evt", W'(o_evt), '0);
        rst = 1'b0;

        // Idle: strobe period and quiet outputs.
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (o_tick) ticks++;
        end
        chk_rng("tick_count_16cyc", ticks, 4, 4);
        chk("idle_sw", o_sw, '0);
        chk("idle_evt", W'(o_evt), '0);

        // Bit 0 rising with latency window.
        raw[0] = 1'b1;
        wait_sw(0, 1'b1, lat);
        chk_rng("rise0_latency", lat, 11, 14);
        chk("rise0_pulse", W'(o_rise[0]), W'(1'b1));
        @(negedge clk);
        chk("rise0_pulse_end", W'(o_rise[0]), '0);
        chk("rise0_evt", W'(o_evt), W'(1'b1));

        // Glitch on bit 3 is rejected.
        raw[3] = 1'b1;
        repeat (6) @(negedge clk);
        raw[3] = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch3_sw", W'(o_sw[3]), '0);
        chk("glitch3_evt", W'(o_evt), W'(1'b1));

        // Return bit 0 low and clear the flag.
        raw = '0;
        wait_pulse(1'b0, v);
        chk("fall0_val", v, 32'h0000_0001);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        chk("evt_cleared", W'(o_evt), '0);

        // Two bits together, then release together; clear on the fall pulse.
        raw = 32'h0000_0011;
        wait_pulse(1'b1, v);
        chk("rise11_val", v, 32'h0000_0011);
        chk("rise11_sw", o_sw, 32'h0000_0011);
        raw = '0;
        wait_pulse(1'b0, v);
        chk("fall11_val", v, 32'h0000_0011);
        clr = 1'b1;
        @(negedge clk);
        chk("set_beats_clr", W'(o_evt), W'(1'b1));
        @(negedge clk);
        chk("clr_alone", W'(o_evt), '0);
        clr = 1'b0;
        chk("fall11_sw", o_sw, '0);

        // Reset in the middle of qualifying bit 5.
        raw[5] = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_reset_sw", o_sw, '0);
        rst = 1'b0;
        wait_sw(5, 1'b1, lat);
        chk_rng("post_reset_latency", lat, 1, 14);
        chk("post_reset_rise5", o_rise, 32'h0000_0020);
        @(negedge clk);
        chk("post_reset_rise5_end", o_rise, '0);

        // Randomized segments against the model.
        for (int s = 0; s < 60; s++) begin
            hold = $urandom_range(1, 20);
            raw  = raw ^ ($urandom & $urandom & $urandom);
            for (int c = 0; c < hold; c++) begin
                clr = ($urandom_range(0, 5) == 0);
                @(negedge clk);
            end
            if (s == 30) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end
        clr = 1'b0;
        repeat (40) @(negedge clk);
        chk("pulse_queue_drained", W'(pulse_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
